id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
ID/EX pipeline register directly downstream of the 8x16 register file. It captures the two read operands and the decode control for one instruction per cycle. Operands are corrected by forwarding from the EX result and the WB write, because register file writes land only at the clock edge. The block detects load-use hazards, inserts bubbles, honours downstream hold and flush, and keeps a stall counter for performance monitoring.

Parameters:
DATA_W, 16, operand/result width
RN_W, 3, register number width (8 registers, R0 is an ordinary register)
OP_W, 4, opaque decode control field passed through
CNT_W, 8, stall counter width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
id_valid  in  1  decode holds a valid instruction
id_readA  in  RN_W  source A register number (also driven to register file readA)
id_readB  in  RN_W  source B register number (also driven to register file readB)
id_useA  in  1  instruction consumes source A
id_useB  in  1  instruction consumes source B
rf_A  in  DATA_W  register file A_out
rf_B  in  DATA_W  register file B_out
id_writenum  in  RN_W  destination register
id_write  in  1  instruction writes a register
id_is_load  in  1  result comes from memory, not available in EX
id_op  in  OP_W  control passthrough
ex_result  in  DATA_W  ALU result of the instruction currently on q_*
wb_write  in  1  register file write this cycle
wb_writenum  in  RN_W  register file writenum this cycle
wb_data  in  DATA_W  register file data_in this cycle
ex_hold  in  1  EX cannot accept a new instruction
flush  in  1  squash the instruction in decode and on q_*
stall  out  1  decode/fetch must hold (combinational)
q_valid  out  1  registered instruction valid
q_A  out  DATA_W  registered operand A
q_B  out  DATA_W  registered operand B
q_writenum  out  RN_W  registered destination
q_write  out  1  registered write enable
q_is_load  out  1  registered load flag
q_op  out  OP_W  registered control
stall_cnt  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Reset: q_* all 0, q_valid 0, stall_cnt 0. stall = 0 while reset is high. Reset overrides every other input.
- ex_fwd_ok = q_valid & q_write & ~q_is_load.
- Operand select, evaluated per source X in {A,B}, in priority order:
  - ex_fwd_ok & q_writenum==id_readX: use ex_result.
  - else wb_write & wb_writenum==id_readX: use wb_data.
  - else: use rf_X.
- Load-use hazard: lu = id_valid & q_valid & q_write & q_is_load & ((id_useA & q_writenum==id_readA) | (id_useB & q_writenum==id_readB)).
- stall = ~reset & ~flush & (ex_hold | lu).
- Next-state rules at each edge, first match wins:
  - flush: q_valid<=0. Other q_* fields are don't-care but hold.
  - ex_hold: all q_* hold. A held q_* keeps forwarding its ex_result.
  - lu: bubble, q_valid<=0. The load advances to WB, and the next cycle forwards it via wb_data. Exactly one stall cycle per load-use unless ex_hold intervenes.
  - otherwise: q_valid<=id_valid. q_A/q_B take the forwarded operands; the remaining q_* take the id_* fields. When id_valid=0, the fields still load but q_write is forced to 0.
- Latency: one cycle from decode to q_*. Forwarding adds no latency.
- stall_cnt increments on each edge where stall=1. It saturates at 2^CNT_W-1 and clears only on reset.
- Flush during a load-use stall clears q_valid and drops stall that same cycle.
- Reset mid-hold discards the held instruction.

Test Plan:
- Reset, then id_valid=1, readA=R2 (rf_A=0x0011), readB=R3 (rf_B=0x0022), no matching writes -> next cycle q_valid=1, q_A=0x0011, q_B=0x0022, stall=0.
- q holds a write to R5 (not a load), ex_result=0xBEEF; the same cycle wb writes R5=0x1234; decode readA=R5, useA=1 -> q_A=0xBEEF (EX wins over WB).
- wb_write=1, wb_writenum=R0, wb_data=0x7777, rf_B stale 0x0000, readB=R0 -> q_B=0x7777.
- q holds a load to R4; decode readB=R4, useB=1 -> stall=1 for exactly one cycle and q_valid=0 (bubble). Next cycle, wb_data=0xCAFE for R4 -> q_B=0xCAFE, stall_cnt=1.
- Same load-use setup with useB=0 and useA=0 -> no stall.
- Assert ex_hold for 3 cycles -> q_* unchanged, stall=1, stall_cnt+=3. Assert flush together with ex_hold -> q_valid=0 next cycle, stall=0. Pulse reset -> all q_* 0 and stall_cnt=0.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//   ID/EX pipeline register sitting right after the 8x16 register file. Each cycle it
//   captures the two read operands and the decode control of one instruction. The register
//   file only commits writes at the clock edge, so the operands are corrected by forwarding:
//   first from the EX result, then from the WB write. Load-use hazards insert one bubble.
//   Downstream hold and flush are honoured. A saturating counter records the stall cycles.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   id_valid                decode holds a valid instruction
//   id_readA/B, id_useA/B   source register numbers and whether each one is consumed
//   rf_A, rf_B              register file read data for id_readA/B
//   id_writenum, id_write   destination register and its write enable
//   id_is_load, id_op       load flag and opaque control passthrough
//   ex_result               ALU result of the instruction currently held on q_*
//   wb_write/num/data       register file write happening this cycle
//   ex_hold, flush          downstream back-pressure and squash
//   stall                   decode/fetch must hold (combinational)
//   q_*                     registered instruction presented to EX
//   stall_cnt               saturating count of cycles with stall=1
module id_ex_operand_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RN_W   = 3,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [RN_W-1:0]   id_readA,
  input  logic [RN_W-1:0]   id_readB,
  input  logic              id_useA,
  input  logic              id_useB,
  input  logic [DATA_W-1:0] rf_A,
  input  logic [DATA_W-1:0] rf_B,
  input  logic [RN_W-1:0]   id_writenum,
  input  logic              id_write,
  input  logic              id_is_load,
  input  logic [OP_W-1:0]   id_op,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              wb_write,
  input  logic [RN_W-1:0]   wb_writenum,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              stall,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_A,
  output logic [DATA_W-1:0] q_B,
  output logic [RN_W-1:0]   q_writenum,
  output logic              q_write,
  output logic              q_is_load,
  output logic [OP_W-1:0]   q_op,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              r_valid;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [RN_W-1:0]   r_writenum;
  logic              r_write;
  logic              r_is_load;
  logic [OP_W-1:0]   r_op;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_ex_fwd_ok;
  logic              w_lu;
  logic              w_stall;
  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;

  // A load's data is not ready in EX, so only non-load writers may forward from EX.
  assign w_ex_fwd_ok = r_valid & r_write & ~r_is_load;

  // EX is the younger write and takes priority over WB.
  always_comb begin
    w_fwd_a = rf_A;
    if (w_ex_fwd_ok && (r_writenum == id_readA)) begin
      w_fwd_a = ex_result;
    end else if (wb_write && (wb_writenum == id_readA)) begin
      w_fwd_a = wb_data;
    end
  end

  always_comb begin
    w_fwd_b = rf_B;
    if (w_ex_fwd_ok && (r_writenum == id_readB)) begin
      w_fwd_b = ex_result;
    end else if (wb_write && (wb_writenum == id_readB)) begin
      w_fwd_b = wb_data;
    end
  end

  // One bubble is enough: next cycle the load sits in WB and forwards through wb_data.
  assign w_lu = id_valid & r_valid & r_write & r_is_load &
                ((id_useA & (r_writenum == id_readA)) |
                 (id_useB & (r_writenum == id_readB)));

  assign w_stall = ~reset & ~flush & (ex_hold | w_lu);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_writenum <= '0;
      r_write    <= 1'b0;
      r_is_load  <= 1'b0;
      r_op       <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (ex_hold) begin
      // Everything holds; the held instruction keeps forwarding its ex_result.
    end else if (w_lu) begin
      r_valid <= 1'b0;
    end else begin
      r_valid    <= id_valid;
      r_a        <= w_fwd_a;
      r_b        <= w_fwd_b;
      r_writenum <= id_writenum;
      r_write    <= id_write & id_valid;
      r_is_load  <= id_is_load;
      r_op       <= id_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall      = w_stall;
  assign q_valid    = r_valid;
  assign q_A        = r_a;
  assign q_B        = r_b;
  assign q_writenum = r_writenum;
  assign q_write    = r_write;
  assign q_is_load  = r_is_load;
  assign q_op       = r_op;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage. The driver pushes the expected q_* contents for
// every cycle that should present a valid instruction; the monitor pops and compares on every
// falling edge where q_valid is high. Stall, bubbles, reset and the counter are checked inline.
module tb_id_ex_operand_stage;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [2:0]  id_readA;
  logic [2:0]  id_readB;
  logic        id_useA;
  logic        id_useB;
  logic [15:0] rf_A;
  logic [15:0] rf_B;
  logic [2:0]  id_writenum;
  logic        id_write;
  logic        id_is_load;
  logic [3:0]  id_op;
  logic [15:0] ex_result;
  logic        wb_write;
  logic [2:0]  wb_writenum;
  logic [15:0] wb_data;
  logic        ex_hold;
  logic        flush;
  logic        stall;
  logic        q_valid;
  logic [15:0] q_A;
  logic [15:0] q_B;
  logic [2:0]  q_writenum;
  logic        q_write;
  logic        q_is_load;
  logic [3:0]  q_op;
  logic [7:0]  stall_cnt;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  wn;
    logic        w;
    logic        ld;
    logic [3:0]  op;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  id_ex_operand_stage dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_readA    (id_readA),
    .id_readB    (id_readB),
    .id_useA     (id_useA),
    .id_useB     (id_useB),
    .rf_A        (rf_A),
    .rf_B        (rf_B),
    .id_writenum (id_writenum),
    .id_write    (id_write),
    .id_is_load  (id_is_load),
    .id_op       (id_op),
    .ex_result   (ex_result),
    .wb_write    (wb_write),
    .wb_writenum (wb_writenum),
    .wb_data     (wb_data),
    .ex_hold     (ex_hold),
    .flush       (flush),
    .stall       (stall),
    .q_valid     (q_valid),
    .q_A         (q_A),
    .q_B         (q_B),
    .q_writenum  (q_writenum),
    .q_write     (q_write),
    .q_is_load   (q_is_load),
    .q_op        (q_op),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [2:0] wn,
                      input logic w, input logic ld, input logic [3:0] op);
    exp_t e;
    e.a = a; e.b = b; e.wn = wn; e.w = w; e.ld = ld; e.op = op;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    id_valid = 0; id_readA = 0; id_readB = 0; id_useA = 0; id_useB = 0;
    rf_A = 0; rf_B = 0; id_writenum = 0; id_write = 0; id_is_load = 0; id_op = 0;
    ex_result = 0; wb_write = 0; wb_writenum = 0; wb_data = 0; ex_hold = 0; flush = 0;
  endtask

  task automatic instr(input logic [2:0] ra, input logic [15:0] da, input logic ua,
                       input logic [2:0] rb, input logic [15:0] db, input logic ub,
                       input logic [2:0] wn, input logic w, input logic ld,
                       input logic [3:0] op);
    id_valid = 1; id_readA = ra; rf_A = da; id_useA = ua;
    id_readB = rb; rf_B = db; id_useB = ub;
    id_writenum = wn; id_write = w; id_is_load = ld; id_op = op;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: each valid q_* presentation consumes exactly one expected entry.
  always @(negedge clk) begin
    if (q_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_q_valid", 32'(q_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("q_A", 32'(q_A), 32'(e.a));
        chk("q_B", 32'(q_B), 32'(e.b));
        chk("q_writenum", 32'(q_writenum), 32'(e.wn));
        chk("q_write", 32'(q_write), 32'(e.w));
        chk("q_is_load", 32'(q_is_load), 32'(e.ld));
        chk("q_op", 32'(q_op), 32'(e.op));
      end
    end
  end

  initial begin
    idle();
    reset   = 1;
    ex_hold = 1;
    tick();
    tick();
    chk("stall_in_reset", 32'(stall), 32'd0);
    chk("rst_q_valid", 32'(q_valid), 32'd0);
    chk("rst_q_A", 32'(q_A), 32'd0);
    chk("rst_q_B", 32'(q_B), 32'd0);
    chk("rst_q_write", 32'(q_write), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    reset = 0;

    // Plain read, no forwarding.
    idle();
    instr(3'd2, 16'h0011, 1, 3'd3, 16'h0022, 1, 3'd5, 1, 0, 4'h3);
    #1 chk("stall_plain", 32'(stall), 32'd0);
    push(16'h0011, 16'h0022, 3'd5, 1, 0, 4'h3);
    tick();

    // EX forward beats WB forward to the same register.
    idle();
    instr(3'd5, 16'h5555, 1, 3'd1, 16'h0101, 1, 3'd6, 0, 0, 4'h1);
    ex_result = 16'hBEEF; wb_write = 1; wb_writenum = 3'd5; wb_data = 16'h1234;
    #1 chk("stall_exfwd", 32'(stall), 32'd0);
    push(16'hBEEF, 16'h0101, 3'd6, 0, 0, 4'h1);
    tick();

    // WB forward to R0 over a stale register file value; issue a load to R4.
    idle();
    instr(3'd1, 16'h0A0A, 1, 3'd0, 16'h0000, 1, 3'd4, 1, 1, 4'h2);
    ex_result = 16'hDEAD; wb_write = 1; wb_writenum = 3'd0; wb_data = 16'h7777;
    #1 chk("stall_wbfwd", 32'(stall), 32'd0);
    push(16'h0A0A, 16'h7777, 3'd4, 1, 1, 4'h2);
    tick();

    // Load-use on B: one bubble.
    idle();
    instr(3'd1, 16'h0A0A, 1, 3'd4, 16'h0000, 1, 3'd7, 1, 0, 4'h5);
    ex_result = 16'hBAD0;
    #1 chk("stall_loaduse", 32'(stall), 32'd1);
    tick();
    chk("bubble_q_valid", 32'(q_valid), 32'd0);
    chk("cnt_after_lu", 32'(stall_cnt), 32'd1);

    // Retry: load value now arrives through WB.
    ex_result = 16'h1111; wb_write = 1; wb_writenum = 3'd4; wb_data = 16'hCAFE;
    #1 chk("stall_retry", 32'(stall), 32'd0);
    push(16'h0A0A, 16'hCAFE, 3'd7, 1, 0, 4'h5);
    tick();
    chk("cnt_after_retry", 32'(stall_cnt), 32'd1);

    // Another load to R4, then a consumer that does not use its sources.
    idle();
    instr(3'd2, 16'h0011, 1, 3'd3, 16'h0022, 1, 3'd4, 1, 1, 4'h6);
    ex_result = 16'h1111;
    push(16'h0011, 16'h0022, 3'd4, 1, 1, 4'h6);
    tick();
    idle();
    instr(3'd4, 16'h4444, 0, 3'd4, 16'h4444, 0, 3'd1, 0, 0, 4'h7);
    ex_result = 16'h2222;
    #1 chk("stall_unused_src", 32'(stall), 32'd0);
    push(16'h4444, 16'h4444, 3'd1, 0, 0, 4'h7);
    tick();

    // Hold for three cycles: q_* unchanged.
    idle();
    instr(3'd1, 16'h9999, 1, 3'd2, 16'h8888, 1, 3'd3, 1, 0, 4'hE);
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_hold", 32'(stall), 32'd1);
      push(16'h4444, 16'h4444, 3'd1, 0, 0, 4'h7);
      tick();
    end
    chk("cnt_after_hold", 32'(stall_cnt), 32'd4);

    // Flush with hold: squash, no stall.
    flush = 1;
    #1 chk("stall_flush_hold", 32'(stall), 32'd0);
    tick();
    chk("flush_q_valid", 32'(q_valid), 32'd0);
    chk("cnt_after_flush", 32'(stall_cnt), 32'd4);

    // Valid instruction, then reset during a hold.
    idle();
    instr(3'd2, 16'h0011, 1, 3'd3, 16'h0022, 1, 3'd2, 1, 0, 4'h9);
    push(16'h0011, 16'h0022, 3'd2, 1, 0, 4'h9);
    tick();
    ex_hold = 1; reset = 1;
    #1 chk("stall_reset_hold", 32'(stall), 32'd0);
    tick();
    chk("rst2_q_valid", 32'(q_valid), 32'd0);
    chk("rst2_q_A", 32'(q_A), 32'd0);
    chk("rst2_q_writenum", 32'(q_writenum), 32'd0);
    chk("rst2_q_op", 32'(q_op), 32'd0);
    chk("rst2_stall_cnt", 32'(stall_cnt), 32'd0);
    reset = 0;

    // id_valid=0: fields load, write forced low.
    idle();
    id_writenum = 3'd3; id_write = 1; id_op = 4'hA;
    tick();
    chk("inv_q_valid", 32'(q_valid), 32'd0);
    chk("inv_q_write", 32'(q_write), 32'd0);
    chk("inv_q_writenum", 32'(q_writenum), 32'd3);
    chk("inv_q_op", 32'(q_op), 32'hA);

    // Flush during a load-use stall.
    idle();
    instr(3'd2, 16'h0011, 1, 3'd3, 16'h0022, 1, 3'd4, 1, 1, 4'hB);
    push(16'h0011, 16'h0022, 3'd4, 1, 1, 4'hB);
    tick();
    idle();
    instr(3'd4, 16'h0000, 1, 3'd0, 16'h0000, 0, 3'd5, 1, 0, 4'hC);
    #1 chk("stall_lu_preflush", 32'(stall), 32'd1);
    flush = 1;
    #1 chk("stall_lu_flush", 32'(stall), 32'd0);
    tick();
    chk("lu_flush_q_valid", 32'(q_valid), 32'd0);
    chk("lu_flush_cnt", 32'(stall_cnt), 32'd0);

    // Counter saturation.
    idle();
    ex_hold = 1;
    repeat (260) tick();
    chk("cnt_saturated", 32'(stall_cnt), 32'd255);
    chk("stall_sat_hold", 32'(stall), 32'd1);

    idle();
    tick();
    tick();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
